if_id_queue: RTL and testbench
==============================

# if_id_queue

Decoupling instruction queue between the instruction-fetch stage and the decode stage. It captures each fetched (PC+4, Instruction) pair and holds it in a small FIFO. It presents entries to decode under a valid/ready handshake. It drives the fetch stage's `freeze` input when full and discards all wrong-path entries when a branch is taken.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `DATA_W`, 32: width of PC and instruction fields.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `if_pc`  input  DATA_W  PC+4 value from fetch stage.
- `if_instruction`  input  DATA_W  fetched instruction.
- `branch_taken`  input  1  flush request; same signal that redirects the fetch PC.
- `freeze`  output  1  stall to fetch stage; fetch holds its PC while high.
- `id_ready`  input  1  decode can accept this cycle (low during decode hazard stall).
- `id_valid`  output  1  head entry is valid.
- `id_pc`  output  DATA_W  head entry PC+4.
- `id_instruction`  output  DATA_W  head entry instruction.
- `count`  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Write (push) = `~freeze & ~branch_taken`. The fetch stage emits one instruction every unfrozen cycle and has no valid signal of its own, so every unfrozen, unflushed cycle pushes.
- Read (pop) = `id_valid & id_ready & ~branch_taken`.
- `freeze` = (`count == DEPTH`). It is derived from registered state only and has no combinational path from `id_ready`.
- When full and decode pops, no push occurs that cycle. Fetch was frozen. `freeze` drops the next cycle.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Flush: `branch_taken` high clears count to 0, resets both pointers to 0, and drops the incoming fetch word. The word in fetch that cycle is wrong-path. Flush overrides push and pop.
- Empty: `id_valid` = 0. `id_pc` and `id_instruction` are driven to 0 (NOP encoding), not to stale storage.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Count saturates logically at DEPTH because push is blocked when full.
- No overflow or underflow is possible under these rules. A debug assertion checks this.

## Timing
- Reset: `count`=0, `id_valid`=0, `id_pc`=0, `id_instruction`=0, `freeze`=0, pointers=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries on the next edge, same as flush.
- Push-to-visible latency is 1 cycle: an entry written at edge N is on `id_*` after edge N, without `IFQ_BYPASS_EN`.
- `freeze` asserts in the cycle after the push that fills the queue.
- The first fetch after flush is pushed in the cycle after `branch_taken` deasserts. It is visible one cycle later.
- Throughput is one entry per cycle sustained while `id_ready` is held high.

## Configuration
- `IFQ_BYPASS_EN` defined: when `count == 0`, push is active, and `id_ready` is high, the incoming `if_pc`/`if_instruction` appear on `id_*` with `id_valid`=1 in the same cycle. The entry is consumed and not stored. Zero-latency path for a straight-line pipeline.
- Not defined: no combinational path from `if_*` to `id_*`. The minimum latency is 1 cycle.

## Structure
- Package `ifq_pkg` holds:
  - `DATA_W` default;
  - typedef `ifq_entry_t` {pc, instruction};
  - NOP constant `IFQ_NOP` = 32'h0.
- Sub-module `ifq_storage`: DEPTH×`ifq_entry_t` register array with one write port and one asynchronous read port. It has no reset.
- Pointer, count, flush and bypass logic live in `if_id_queue`.

## Test plan
- Reset, then push 0x1000_0004/0xE3A0_1001 with `id_ready`=0 → next cycle `id_valid`=1, `id_pc`=0x1000_0004, `count`=1.
- `id_ready`=0 while pushing 4 consecutive words → `count`=4 and `freeze`=1. Set `id_ready`=1 for one cycle → head pops, no push, `count`=3, `freeze`=0 the next cycle.
- Queue at 3 entries, `branch_taken`=1 with concurrent `id_ready`=1 → next cycle `count`=0, `id_valid`=0, `id_*`=0. The incoming word is not stored.
- Streaming with `id_ready`=1 for 12 cycles and PCs 4,8,…,48 → output order and values match, and pointers wrap with no loss or duplication.
- `rst` asserted while `count`=2 and `freeze`=0 → all outputs at reset values after the edge. The push on the next non-reset cycle lands at entry 0.
- Build with `IFQ_BYPASS_EN`, empty queue, `id_ready`=1, push 0x0000_0008/0xE080_2003 → same cycle `id_valid`=1 with those values, and `count` stays 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package ifq_pkg;

  localparam int unsigned IFQ_DATA_W = 32;

  typedef struct packed {
    logic [IFQ_DATA_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instruction;
  } ifq_entry_t;

  localparam logic [IFQ_DATA_W-1:0] IFQ_NOP = 32'h0;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the IF/ID queue: one write port, one asynchronous read port.
// Contents are don't-care after reset, so the array carries no reset.
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  ifq_entry_t               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output ifq_entry_t               rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling FIFO between fetch and decode with freeze-on-full and branch flush.
// Define IFQ_BYPASS_EN for a zero-latency path from fetch to decode when empty.
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = IFQ_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          if_pc,
  input  logic [DATA_W-1:0]          if_instruction,
  input  logic                       branch_taken,
  output logic                       freeze,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [DATA_W-1:0]          id_pc,
  output logic [DATA_W-1:0]          id_instruction,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       empty;
  logic       push;
  logic       bypass;
  logic       wr_en;
  logic       rd_en;
  ifq_entry_t wr_entry;
  ifq_entry_t rd_entry;

  assign empty  = (count_q == '0);
  assign freeze = (count_q == CNT_W'(DEPTH));
  assign push   = ~freeze & ~branch_taken;

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & push & id_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word is consumed directly and never stored.
  assign wr_en = push & ~bypass;
  assign rd_en = ~empty & id_ready & ~branch_taken;

  assign wr_entry.pc          = IFQ_DATA_W'(if_pc);
  assign wr_entry.instruction = IFQ_DATA_W'(if_instruction);

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (branch_taken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty queue presents a NOP rather than stale storage.
  always_comb begin
    id_valid       = ~empty;
    id_pc          = empty ? DATA_W'(IFQ_NOP) : DATA_W'(rd_entry.pc);
    id_instruction = empty ? DATA_W'(IFQ_NOP) : DATA_W'(rd_entry.instruction);
    if (bypass) begin
      id_valid       = 1'b1;
      id_pc          = if_pc;
      id_instruction = if_instruction;
    end
  end

  assign count = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(wr_en && freeze) && (count_q <= CNT_W'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(rd_en && empty));

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        branch_taken;
  logic        freeze;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model_q [$];   // {pc, instruction}, head at index 0

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .branch_taken   (branch_taken),
    .freeze         (freeze),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then apply the model update at posedge.
  task automatic cycle(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                       input logic b, input logic rd);
    int   sz;
    logic full, do_push, byp, do_pop;
    logic [63:0] head;
    @(negedge clk);
    rst = r; if_pc = pc; if_instruction = ins; branch_taken = b; id_ready = rd;
    #1;
    sz      = model_q.size();
    full    = (sz == DEPTH);
    do_push = !full && !b;
    byp     = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (sz == 0) && do_push && rd;
`endif
    head = (sz > 0) ? model_q[0] : 64'h0;
    if (byp) head = {pc, ins};
    check("freeze", 64'(freeze), 64'(full));
    check("count",  64'(count), 64'(sz));
    check("valid",  64'(id_valid), 64'(sz > 0 || byp));
    check("pc",     64'(id_pc), 64'(head[63:32]));
    check("instr",  64'(id_instruction), 64'(head[31:0]));
    @(posedge clk);
    if (r || b) begin
      model_q.delete();
    end else if (!byp) begin
      if (sz > 0 && rd) void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
    end
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; if_instruction = '0; branch_taken = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_q.delete();
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_freeze", 64'(freeze), 64'd0);
    check("rst_pc", 64'(id_pc), 64'd0);

    // First push becomes visible one cycle later.
    cycle(1'b0, 32'h1000_0004, 32'hE3A0_1001, 1'b0, 1'b0);
    #2;
    check("first_pc", 64'(id_pc), 64'h1000_0004);
    check("first_count", 64'(count), 64'd1);
    check("first_valid", 64'(id_valid), 64'd1);

    // Fill to DEPTH, then a single pop while frozen.
    for (int i = 1; i < 4; i++) cycle(1'b0, 32'h1000_0004 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    #2;
    check("full_count", 64'(count), 64'd4);
    check("full_freeze", 64'(freeze), 64'd1);
    cycle(1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 1'b0, 1'b1);
    #2;
    check("pop_count", 64'(count), 64'd3);
    check("pop_freeze", 64'(freeze), 64'd0);
    check("pop_head", 64'(id_pc), 64'h1000_0008);

    // Flush with 3 entries and concurrent ready.
    cycle(1'b0, 32'hBAD0_0000, 32'hBAD0_0001, 1'b1, 1'b1);
    #2;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(id_valid), 64'd0);
    check("flush_pc", 64'(id_pc), 64'd0);
    check("flush_instr", 64'(id_instruction), 64'd0);

    // Streaming with pointer wrap.
    for (int i = 1; i <= 12; i++) cycle(1'b0, 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-operation at two entries.
    cycle(1'b0, 32'h0000_0100, 32'h1111_0000, 1'b0, 1'b0);
    cycle(1'b0, 32'h0000_0104, 32'h1111_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0108, 32'h1111_0002, 1'b0, 1'b0);
    #2;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(id_valid), 64'd0);
    check("midrst_pc", 64'(id_pc), 64'd0);
    cycle(1'b0, 32'h0000_0200, 32'h2222_0000, 1'b0, 1'b0);
    #2;
    check("postrst_pc", 64'(id_pc), 64'h0000_0200);
    check("postrst_count", 64'(count), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IFQ_BYPASS_EN
    @(negedge clk);
    rst = 1'b0; if_pc = 32'h0000_0008; if_instruction = 32'hE080_2003; branch_taken = 1'b0; id_ready = 1'b1;
    #1;
    check("byp_valid", 64'(id_valid), 64'd1);
    check("byp_pc", 64'(id_pc), 64'h0000_0008);
    check("byp_instr", 64'(id_instruction), 64'hE080_2003);
    @(posedge clk);
    #2;
    check("byp_count", 64'(count), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 2, $urandom, $urandom,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 55);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
